me_controller: RTL and testbench

Sequencing controller for the block-matching motion-estimation datapath. It accepts a start request and fetches the current-block rows and search-window rows from the frame buffer. It drives the datapath's 3-bit `state` code each cycle, and issues `comparator_init`, `comp_start16` and `address16` so each candidate SAD reaches the comparator tagged with its position. It sits directly upstream of `me_datapath` and drives every control input of that block.

---
 rtl/me_controller_if.sv | 26 ++
 rtl/me_controller.sv | 165 ++++++++++++++++
 tb/tb_me_controller.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_controller_if.sv
// Control/handshake bundle between the request side, me_controller and the
// frame buffer / me_datapath control inputs.
interface me_controller_if;
  logic        start;
  logic        abort;
  logic [11:0] cur_base;
  logic [11:0] srch_base;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [2:0]  state;
  logic        comparator_init;
  logic        comp_start16;
  logic [9:0]  address16;
  logic        busy;
  logic        done;

  modport master (
    output start, abort, cur_base, srch_base,
    input  mem_rd, mem_addr, state, comparator_init, comp_start16, address16, busy, done
  );

  modport slave (
    input  start, abort, cur_base, srch_base,
    output mem_rd, mem_addr, state, comparator_init, comp_start16, address16, busy, done
  );
endinterface

// File: rtl/me_controller.sv
// Sequencing controller for the block-matching motion-estimation datapath:
// loads current/search rows, steps the candidate scan and tags SADs for the comparator.
module me_controller #(
  parameter int unsigned NUM_V   = 4,
  parameter int unsigned NUM_H   = 4,
  parameter int unsigned SAD_LAT = 3
) (
  input  logic            clk,
  input  logic            reset,
  me_controller_if.slave  bus
);

  localparam int unsigned AW       = 12;
  localparam int unsigned PW       = 10;
  localparam logic [4:0]  V_LAST   = 5'(NUM_V - 1);
  localparam logic [4:0]  H_LAST   = 5'(NUM_H - 1);
  localparam logic [3:0]  ROW_LAST = 4'd15;

  typedef enum logic [2:0] {IDLE, LD_CUR, LD_SRCH, SHIFT, ROWADV, DRAIN} fsm_t;

  fsm_t          fsm, fsm_n;
  logic [3:0]    cnt, cnt_n;
  logic [4:0]    v, v_n, h, h_n;
  logic [AW-1:0] cur_q, srch_q, addr_q;
  logic          rd_n;
  logic [AW-1:0] raddr_n;
  logic          accept;
  logic [SAD_LAT-1:0] pv;
  logic [PW-1:0]      pa [SAD_LAT];

  // Abort wins over start; reset gates the combinational read strobe
  assign accept = (fsm == IDLE) && bus.start && !bus.abort && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) fsm <= IDLE;
    else        fsm <= fsm_n;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      v      <= '0;
      h      <= '0;
      cur_q  <= '0;
      srch_q <= '0;
      addr_q <= '0;
    end else begin
      cnt <= cnt_n;
      v   <= v_n;
      h   <= h_n;
      if (accept) begin
        cur_q  <= bus.cur_base;
        srch_q <= bus.srch_base;
      end
      if (rd_n) addr_q <= raddr_n;
    end
  end

  // Next state; the read for a row is issued in the cycle before it is consumed
  always_comb begin
    fsm_n   = fsm;
    cnt_n   = cnt;
    v_n     = v;
    h_n     = h;
    rd_n    = 1'b0;
    raddr_n = addr_q;
    unique case (fsm)
      IDLE: begin
        if (accept) begin
          fsm_n   = LD_CUR;
          cnt_n   = '0;
          rd_n    = 1'b1;
          raddr_n = bus.cur_base;
        end
      end
      LD_CUR: begin
        rd_n = 1'b1;
        if (cnt == ROW_LAST) begin
          fsm_n   = LD_SRCH;
          cnt_n   = '0;
          raddr_n = srch_q;
        end else begin
          cnt_n   = cnt + 4'd1;
          raddr_n = cur_q + AW'(cnt) + 12'd1;
        end
      end
      LD_SRCH: begin
        if (cnt == ROW_LAST) begin
          fsm_n = SHIFT;
          v_n   = '0;
          h_n   = '0;
        end else begin
          cnt_n   = cnt + 4'd1;
          rd_n    = 1'b1;
          raddr_n = srch_q + AW'(cnt) + 12'd1;
        end
      end
      SHIFT: begin
        if (h == H_LAST) begin
          if (v == V_LAST) begin
            fsm_n = DRAIN;
          end else begin
            fsm_n   = ROWADV;
            rd_n    = 1'b1;
            raddr_n = srch_q + 12'd16 + AW'(v);
          end
        end else begin
          h_n = h + 5'd1;
        end
      end
      ROWADV: begin
        fsm_n = SHIFT;
        v_n   = v + 5'd1;
        h_n   = '0;
      end
      DRAIN: begin
        if (pv == '0) fsm_n = IDLE;
      end
      default: fsm_n = IDLE;
    endcase
    if (bus.abort && (fsm != IDLE)) begin
      fsm_n   = IDLE;
      rd_n    = 1'b0;
      raddr_n = addr_q;
    end
  end

  // Outputs decoded from registered state and pipeline
  always_comb begin
    bus.state           = 3'd0;
    bus.comparator_init = 1'b0;
    bus.busy            = (fsm != IDLE);
    bus.done            = (fsm == DRAIN) && (pv == '0);
    bus.mem_rd          = rd_n;
    bus.mem_addr        = raddr_n;
    bus.comp_start16    = pv[SAD_LAT-1];
    bus.address16       = pa[SAD_LAT-1];
    unique case (fsm)
      LD_CUR:  begin
        bus.state           = 3'd1;
        bus.comparator_init = (cnt == 4'd0);
      end
      LD_SRCH: bus.state = 3'd2;
      SHIFT:   bus.state = 3'd4;
      ROWADV:  bus.state = 3'd5;
      default: bus.state = 3'd0;
    endcase
  end

  // Candidate tag pipeline aligned with the datapath SAD latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pv <= '0;
      for (int i = 0; i < SAD_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0] <= (fsm == SHIFT) && !bus.abort;
      pa[0] <= {v, h};
      for (int i = 1; i < SAD_LAT; i++) begin
        pv[i] <= pv[i-1] && !bus.abort;
        pa[i] <= pa[i-1];
      end
    end
  end

endmodule

// File: tb/tb_me_controller.sv
// Scoreboard bench for me_controller: a run-level model predicts every strobe,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_me_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  me_controller_if b0();
  me_controller_if b1();

  me_controller dut0 (.clk(clk), .reset(reset), .bus(b0));
  me_controller #(.NUM_V(1), .NUM_H(1), .SAD_LAT(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct { int cy; int val; } ev_t;
  ev_t q_rd[$], q_st[$], q_init[$], q_cmp[$], q_done[$];

  int cyc = 0;
  int vectors = 0;
  int errors = 0;
  int cut_rd = 32'h3fffffff;
  int cut_oth = 32'h3fffffff;
  logic sel = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  logic        m_rd, m_init, m_cmp, m_busy, m_done;
  logic [11:0] m_addr;
  logic [2:0]  m_state;
  logic [9:0]  m_a16;
  assign m_rd    = sel ? b1.mem_rd          : b0.mem_rd;
  assign m_addr  = sel ? b1.mem_addr        : b0.mem_addr;
  assign m_state = sel ? b1.state           : b0.state;
  assign m_init  = sel ? b1.comparator_init : b0.comparator_init;
  assign m_cmp   = sel ? b1.comp_start16    : b0.comp_start16;
  assign m_a16   = sel ? b1.address16       : b0.address16;
  assign m_busy  = sel ? b1.busy            : b0.busy;
  assign m_done  = sel ? b1.done            : b0.done;

  function automatic string kname(input int k);
    case (k)
      0:       return "mem_rd/mem_addr";
      1:       return "busy/state";
      2:       return "comparator_init";
      3:       return "comp_start16/address16";
      default: return "done";
    endcase
  endfunction

  task automatic push(input int k, input int cy, input int val);
    ev_t e;
    e.cy = cy;
    e.val = val;
    if ((k == 0) ? (cy < cut_rd) : (cy <= cut_oth)) begin
      case (k)
        0:       q_rd.push_back(e);
        1:       q_st.push_back(e);
        2:       q_init.push_back(e);
        3:       q_cmp.push_back(e);
        default: q_done.push_back(e);
      endcase
    end
  endtask

  // Run-level model: row schedule, scan order and latency from the operation rules
  task automatic predict(input int c0, input int cb, input int sb, input int nv, input int nh, input int sl);
    int t;
    for (int i = 0; i < 16; i++) begin
      push(0, c0 + i, (cb + i) & 'hFFF);
      push(1, c0 + 1 + i, 1);
    end
    for (int r = 0; r < 16; r++) begin
      push(0, c0 + 16 + r, (sb + r) & 'hFFF);
      push(1, c0 + 17 + r, 2);
    end
    push(2, c0 + 1, 0);
    t = c0 + 33;
    for (int v = 0; v < nv; v++) begin
      for (int h = 0; h < nh; h++) begin
        push(1, t, 4);
        push(3, t + sl, v * 32 + h);
        t++;
      end
      if (v < nv - 1) begin
        push(0, t - 1, (sb + 16 + v) & 'hFFF);
        push(1, t, 5);
        t++;
      end
    end
    for (int d = t; d <= t + sl; d++) push(1, d, 0);
    push(4, t + sl, 0);
    cut_rd = 32'h3fffffff;
    cut_oth = 32'h3fffffff;
  endtask

  task automatic got(input int k, input int val);
    ev_t e;
    bit have;
    have = 1'b0;
    e.cy = 0;
    e.val = 0;
    case (k)
      0: if (q_rd.size() != 0)   begin e = q_rd.pop_front();   have = 1'b1; end
      1: if (q_st.size() != 0)   begin e = q_st.pop_front();   have = 1'b1; end
      2: if (q_init.size() != 0) begin e = q_init.pop_front(); have = 1'b1; end
      3: if (q_cmp.size() != 0)  begin e = q_cmp.pop_front();  have = 1'b1; end
      default: if (q_done.size() != 0) begin e = q_done.pop_front(); have = 1'b1; end
    endcase
    vectors++;
    if (!have) begin
      errors++;
      $display("FAIL %s: got value %0d at cycle %0d, required no event", kname(k), val, cyc);
    end else if (e.cy != cyc || e.val != val) begin
      errors++;
      $display("FAIL %s: got value %0d at cycle %0d, required value %0d at cycle %0d",
               kname(k), val, cyc, e.val, e.cy);
    end
  endtask

  always @(negedge clk) begin
    if (m_rd)   got(0, int'(m_addr));
    if (m_busy) got(1, int'(m_state));
    else begin
      vectors++;
      if (m_state != 3'd0) begin
        errors++;
        $display("FAIL idle state: got %0d at cycle %0d, required 0", m_state, cyc);
      end
    end
    if (m_init) got(2, 0);
    if (m_cmp)  got(3, int'(m_a16));
    if (m_done) got(4, 0);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic check_zero(input string nm);
    logic [30:0] all;
    all = {m_rd, m_addr, m_state, m_init, m_cmp, m_a16, m_busy, m_done};
    vectors++;
    if (all != '0) begin
      errors++;
      $display("FAIL %s: got outputs 0x%0h at cycle %0d, required 0", nm, all, cyc);
    end
  endtask

  task automatic chk_empty(input string nm, input int sz);
    vectors++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: got %0d expected events never seen, required 0", nm, sz);
    end
  endtask

  task automatic start0(input logic [11:0] cb, input logic [11:0] sb);
    b0.cur_base = cb;
    b0.srch_base = sb;
    b0.start = 1'b1;
    predict(cyc, int'(cb), int'(sb), 4, 4, 3);
    step(1);
    b0.start = 1'b0;
  endtask

  initial begin
    int c, ca, gap;
    logic [11:0] cb, sb;
    b0.start = 1'b0; b0.abort = 1'b0; b0.cur_base = '0; b0.srch_base = '0;
    b1.start = 1'b0; b1.abort = 1'b0; b1.cur_base = '0; b1.srch_base = '0;
    step(3);
    check_zero("reset outputs");
    reset = 1'b1;
    step(2);

    // Directed default run, ignored start mid-run, back-to-back with search wrap
    c = cyc;
    start0(12'h100, 12'h200);
    step_to(c + 20);
    b0.start = 1'b1;
    b0.cur_base = 12'h555;
    step(1);
    b0.start = 1'b0;
    step_to(c + 55);
    b0.cur_base = 12'h3C0;
    b0.srch_base = 12'hFF8;
    b0.start = 1'b1;
    predict(c + 56, 'h3C0, 'hFF8, 4, 4, 3);
    step(2);
    b0.start = 1'b0;
    step_to(c + 56 + 60);

    // Abort at cycle 40
    c = cyc;
    cut_rd = c + 40;
    cut_oth = c + 40;
    b0.cur_base = 12'h0A0; b0.srch_base = 12'h7F0; b0.start = 1'b1;
    predict(c, 'h0A0, 'h7F0, 4, 4, 3);
    step(1);
    b0.start = 1'b0;
    step_to(c + 40);
    b0.abort = 1'b1;
    step(1);
    b0.abort = 1'b0;
    step(20);

    // Abort and start together in IDLE: nothing accepted
    b0.start = 1'b1;
    b0.abort = 1'b1;
    step(1);
    b0.start = 1'b0;
    b0.abort = 1'b0;
    step(60);

    // Reset mid-load at cycle 25, then a clean run
    c = cyc;
    cut_rd = c + 25;
    cut_oth = c + 24;
    b0.cur_base = 12'h321; b0.srch_base = 12'h654; b0.start = 1'b1;
    predict(c, 'h321, 'h654, 4, 4, 3);
    step(1);
    b0.start = 1'b0;
    step_to(c + 25);
    reset = 1'b0;
    #3;
    check_zero("mid-run reset outputs");
    step(1);
    reset = 1'b1;
    step(2);
    c = cyc;
    start0(12'($urandom), 12'($urandom));
    step_to(c + 60);

    // Randomized runs with optional abort
    for (int n = 0; n < 6; n++) begin
      gap = int'($urandom_range(0, 4));
      step(gap);
      c = cyc;
      cb = 12'($urandom);
      sb = 12'($urandom);
      ca = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 54)) : 0;
      if (ca != 0) begin
        cut_rd = c + ca;
        cut_oth = c + ca;
      end
      start0(cb, sb);
      if (ca != 0) begin
        step_to(c + ca);
        b0.abort = 1'b1;
        step(1);
        b0.abort = 1'b0;
        step(2);
      end else begin
        step_to(c + 56);
      end
    end
    step(60);

    // Minimal configuration: one offset, one shift, single-cycle latency
    sel = 1'b1;
    step(2);
    for (int n = 0; n < 3; n++) begin
      c = cyc;
      cb = 12'($urandom);
      sb = (n == 0) ? 12'hFF8 : 12'($urandom);
      b1.cur_base = cb;
      b1.srch_base = sb;
      b1.start = 1'b1;
      predict(c, int'(cb), int'(sb), 1, 1, 1);
      step(1);
      b1.start = 1'b0;
      step_to(c + 36 + n);
    end
    step(5);

    chk_empty(kname(0), q_rd.size());
    chk_empty(kname(1), q_st.size());
    chk_empty(kname(2), q_init.size());
    chk_empty(kname(3), q_cmp.size());
    chk_empty(kname(4), q_done.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
